// File: rtl/bus_pkg.sv
// Shared types and helpers for the 8085-style bus cycle sequencer.
//   t_state_e : T-state encoding of the sequencer FSM
//   t_cyc_e   : transfer type as presented on req_type (5-7 reserved)
//   ST_*      : S1/S0 status encodings
package bus_pkg;

    typedef enum logic [2:0] {
        TI, T1, T2, TW, T3, T4, THOLD
    } t_state_e;

    typedef enum logic [2:0] {
        CYC_FETCH = 3'd0,
        CYC_MRD   = 3'd1,
        CYC_MWR   = 3'd2,
        CYC_IORD  = 3'd3,
        CYC_IOWR  = 3'd4
    } t_cyc_e;

    localparam logic [1:0] ST_FETCH = 2'b11;
    localparam logic [1:0] ST_READ  = 2'b10;
    localparam logic [1:0] ST_WRITE = 2'b01;
    localparam logic [1:0] ST_HALT  = 2'b00;

    function automatic logic cyc_valid(input logic [2:0] t);
        return t <= 3'(CYC_IOWR);
    endfunction

    function automatic logic cyc_is_write(input logic [2:0] t);
        return (t == 3'(CYC_MWR)) || (t == 3'(CYC_IOWR));
    endfunction

    function automatic logic cyc_is_io(input logic [2:0] t);
        return (t == 3'(CYC_IORD)) || (t == 3'(CYC_IOWR));
    endfunction

    function automatic logic [1:0] cyc_status(input logic [2:0] t);
        case (t)
            3'(CYC_FETCH):           return ST_FETCH;
            3'(CYC_MRD), 3'(CYC_IORD): return ST_READ;
            3'(CYC_MWR), 3'(CYC_IOWR): return ST_WRITE;
            default:                 return ST_HALT;
        endcase
    endfunction

endpackage

// File: rtl/bus_cycle_ctrl_wait_timer.sv
// Wait-state counter for the bus sequencer.
//   load_i : set the count to 1 (first TW)
//   inc_i  : advance the count by one
//   tc_o   : count has reached WAIT_MAX
module wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic inc_i,
    output logic tc_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)     cnt_d = 8'd1;
        else if (inc_i) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == 8'(WAIT_MAX));

endmodule

// File: rtl/bus_cycle_ctrl.sv
// 8085-style machine-cycle sequencer. Accepts one transfer at a time from
// the core and walks it through T1/T2/[TW..]/T3/[T4], driving ALE, S1/S0,
// IOMn, RDn, WRn and the multiplexed AD bus; yields the bus to HOLD between
// cycles.
//   req/req_type/req_addr/req_wdata : transfer request (captured on accept)
//   busy/done/err/rdata             : status back to the core
//   ALE,S0,S1,IOMn,RDn,WRn,ad_*,a_hi,bus_oe : system bus
//   READY : slave ready (low = wait), HOLD/HLDA : bus arbitration
module bus_cycle_ctrl
    import bus_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [2:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              ALE,
    output logic              S0,
    output logic              S1,
    output logic              IOMn,
    output logic              RDn,
    output logic              WRn,
    output logic [DATA_W-1:0] ad_out,
    output logic              ad_oe,
    input  logic [DATA_W-1:0] ad_in,
    output logic [ADDR_W-9:0] a_hi,
    output logic              bus_oe,
    input  logic              READY,
    input  logic              HOLD,
    output logic              HLDA
);

    t_state_e          state_q, state_d;
    logic [2:0]        type_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              timeout_q;
    logic              done_q, err_q;
    logic [DATA_W-1:0] rdata_q;

    logic accept, tmr_load, tmr_inc, tmr_tc, to_set, fin, fin_err, rd_latch;

    wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait (
        .clk    (clk),
        .rst_n  (rst),
        .load_i (tmr_load),
        .inc_i  (tmr_inc),
        .tc_o   (tmr_tc)
    );

    // Next state and per-edge control strobes.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        tmr_load = 1'b0;
        tmr_inc  = 1'b0;
        to_set   = 1'b0;
        fin      = 1'b0;
        fin_err  = 1'b0;
        rd_latch = 1'b0;
        case (state_q)
            TI: begin
                // HOLD wins over a pending request.
                if (HOLD) state_d = THOLD;
                else if (req) begin
                    state_d = T1;
                    accept  = 1'b1;
                end
            end
            T1: begin
                if (!cyc_valid(type_q)) begin
                    state_d = TI;
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    state_d = T2;
                end
            end
            T2: begin
                if (READY) state_d = T3;
                else begin
                    state_d  = TW;
                    tmr_load = 1'b1;
                end
            end
            TW: begin
                if (READY) state_d = T3;
                else if (tmr_tc) begin
                    state_d = T3;
                    to_set  = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            T3: begin
                // A timed-out read never had valid data on AD.
                rd_latch = !cyc_is_write(type_q) && !timeout_q;
                if (type_q == 3'(CYC_FETCH)) state_d = T4;
                else begin
                    state_d = TI;
                    fin     = 1'b1;
                    fin_err = timeout_q;
                end
            end
            T4: begin
                state_d = TI;
                fin     = 1'b1;
                fin_err = timeout_q;
            end
            THOLD: begin
                if (!HOLD) state_d = TI;
            end
            default: state_d = TI;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= TI;
            type_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= fin;
            err_q   <= fin_err;
            if (accept) begin
                type_q    <= req_type;
                addr_q    <= req_addr;
                wdata_q   <= req_wdata;
                timeout_q <= 1'b0;
            end else if (to_set) begin
                timeout_q <= 1'b1;
            end
            if (rd_latch) rdata_q <= ad_in;
        end
    end

    // Moore bus decode from state and the captured request.
    logic in_cyc, is_wr;
    logic [1:0] st;

    always_comb begin
        is_wr  = cyc_is_write(type_q);
        in_cyc = cyc_valid(type_q) &&
                 (state_q == T1 || state_q == T2 || state_q == TW ||
                  state_q == T3 || state_q == T4);
        st     = ST_HALT;
        ALE    = 1'b0;
        IOMn   = 1'b0;
        RDn    = 1'b1;
        WRn    = 1'b1;
        ad_out = '0;
        ad_oe  = 1'b0;
        a_hi   = '0;
        bus_oe = 1'b1;
        HLDA   = 1'b0;
        if (in_cyc) begin
            st   = cyc_status(type_q);
            IOMn = cyc_is_io(type_q);
            a_hi = addr_q[ADDR_W-1:8];
            case (state_q)
                T1: begin
                    ALE    = 1'b1;
                    ad_oe  = 1'b1;
                    ad_out = DATA_W'(addr_q[7:0]);
                end
                T2, TW, T3: begin
                    if (is_wr) begin
                        WRn    = 1'b0;
                        ad_oe  = 1'b1;
                        ad_out = wdata_q;
                    end else begin
                        RDn = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        if (state_q == THOLD) begin
            HLDA   = 1'b1;
            bus_oe = 1'b0;
        end
    end

    assign S1    = st[1];
    assign S0    = st[0];
    assign busy  = (state_q != TI);
    assign done  = done_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
module tb_bus_cycle_ctrl;

    localparam int WAIT_MAX = 15;

    logic clk = 1'b0, rst = 1'b0;
    logic req = 1'b0;
    logic [2:0] req_type = '0;
    logic [15:0] req_addr = '0;
    logic [7:0] req_wdata = '0, ad_in = '0;
    logic READY = 1'b1, HOLD = 1'b0;
    logic busy, done, err, ALE, S0, S1, IOMn, RDn, WRn, ad_oe, bus_oe, HLDA;
    logic [7:0] rdata, ad_out, a_hi;

    bus_cycle_ctrl #(.ADDR_W(16), .DATA_W(8), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst), .req(req), .req_type(req_type),
        .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .done(done),
        .err(err), .rdata(rdata), .ALE(ALE), .S0(S0), .S1(S1), .IOMn(IOMn),
        .RDn(RDn), .WRn(WRn), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in),
        .a_hi(a_hi), .bus_oe(bus_oe), .READY(READY), .HOLD(HOLD), .HLDA(HLDA)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy, done, err;
        logic [7:0] rdata;
        logic       ale;
        logic [1:0] s;
        logic       iom, rdn, wrn;
        logic [7:0] ad_out;
        logic       ad_oe;
        logic [7:0] a_hi;
        logic       bus_oe, hlda;
    } row_t;

    int nchk = 0, nerr = 0, cyc = 0;
    row_t expq[$];

    // model state
    logic [7:0] rd_m = '0;
    logic pend_done = 1'b0, pend_err = 1'b0;

    // measured per completed transfer by the compare process
    int lowcnt = 0, busycnt = 0, last_low = 0, last_busy = 0;
    logic last_err = 1'b0;

    function automatic row_t act_row();
        return {busy, done, err, rdata, ALE, S1, S0, IOMn, RDn, WRn,
                ad_out, ad_oe, a_hi, bus_oe, HLDA};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // compare process: one expected row per cycle whenever the stimulus queued one
    always @(negedge clk) begin
        cyc++;
        if (expq.size() > 0) chk("cycle", 64'(act_row()), 64'(expq.pop_front()));
        if (!rst) begin
            lowcnt = 0; busycnt = 0;
        end else if (done) begin
            last_low = lowcnt; last_busy = busycnt; last_err = err;
            lowcnt = 0; busycnt = 0;
        end else begin
            if (!RDn || !WRn) lowcnt++;
            if (busy) busycnt++;
        end
    end

    // ---- model rows ----
    function automatic logic [1:0] st_of(input logic [2:0] t);
        case (t)
            3'd0: return 2'b11;
            3'd1, 3'd3: return 2'b10;
            3'd2, 3'd4: return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic row_t idle_row();
        row_t r = '0;
        r.rdata = rd_m; r.rdn = 1'b1; r.wrn = 1'b1; r.bus_oe = 1'b1;
        r.done = pend_done; r.err = pend_err;
        return r;
    endfunction

    function automatic row_t cyc_row(input logic [2:0] t, input logic [15:0] a);
        row_t r = idle_row();
        r.done = 1'b0; r.err = 1'b0; r.busy = 1'b1;
        if (t <= 3'd4) begin
            r.s = st_of(t); r.iom = (t == 3'd3 || t == 3'd4); r.a_hi = a[15:8];
        end
        return r;
    endfunction

    function automatic row_t t1_row(input logic [2:0] t, input logic [15:0] a);
        row_t r = cyc_row(t, a);
        r.ale = 1'b1; r.ad_oe = 1'b1; r.ad_out = a[7:0];
        return r;
    endfunction

    function automatic row_t strobe_row(input logic [2:0] t, input logic [15:0] a, input logic [7:0] wd);
        row_t r = cyc_row(t, a);
        if (t == 3'd2 || t == 3'd4) begin
            r.wrn = 1'b0; r.ad_oe = 1'b1; r.ad_out = wd;
        end else r.rdn = 1'b0;
        return r;
    endfunction

    function automatic row_t hold_row();
        row_t r = idle_row();
        r.done = 1'b0; r.err = 1'b0; r.busy = 1'b1; r.hlda = 1'b1; r.bus_oe = 1'b0;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic push(input row_t r);
        expq.push_back(r);
    endtask

    // Starts in a TI cycle; returns after the final T-state with the done cycle pending.
    task automatic run_txn(input logic [2:0] t, input logic [15:0] a, input logic [7:0] wd,
                           input int nwait, input logic [7:0] adin, input bit hold_t2);
        int ntw;
        bit to;
        ntw = (nwait > WAIT_MAX) ? WAIT_MAX : nwait;
        to  = (nwait > WAIT_MAX);
        push(idle_row()); pend_done = 1'b0; pend_err = 1'b0;
        req = 1'b1; req_type = t; req_addr = a; req_wdata = wd; ad_in = adin; READY = 1'b1;
        tick();
        // later request changes must be ignored
        req = 1'b0; req_addr = ~a; req_wdata = ~wd; req_type = 3'd1;
        if (t > 3'd4) begin
            push(cyc_row(t, a)); tick();
            pend_done = 1'b1; pend_err = 1'b1;
            return;
        end
        push(t1_row(t, a)); tick();
        push(strobe_row(t, a, wd)); READY = (nwait == 0); if (hold_t2) HOLD = 1'b1; tick();
        for (int i = 1; i <= ntw; i++) begin
            push(strobe_row(t, a, wd)); READY = (i >= nwait); tick();
        end
        push(strobe_row(t, a, wd)); READY = 1'b1; tick();
        if (!(t == 3'd2 || t == 3'd4) && !to) rd_m = adin;
        if (t == 3'd0) begin
            push(cyc_row(t, a)); tick();
        end
        pend_done = 1'b1; pend_err = to;
    endtask

    task automatic idle_cycle();
        push(idle_row()); pend_done = 1'b0; pend_err = 1'b0; tick();
    endtask

    initial begin
        #1;
        // reset values (literal)
        chk("reset", 64'(act_row()), 64'({1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1,
                                         8'h00, 1'b0, 8'h00, 1'b1, 1'b0}));
        @(posedge clk); #2; rst = 1'b1;

        // memory read, no waits
        run_txn(3'd1, 16'h20A5, 8'h00, 0, 8'h3C, 0);
        idle_cycle();
        chk("mrd_rdata", 64'(rdata), 64'h3C);
        chk("mrd_rd_low", 64'(last_low), 64'd2);
        chk("mrd_err", 64'(last_err), 64'd0);

        // opcode fetch with T4
        run_txn(3'd0, 16'h0000, 8'h00, 0, 8'h76, 0);
        idle_cycle();
        chk("fetch_rdata", 64'(rdata), 64'h76);
        chk("fetch_busy", 64'(last_busy), 64'd4);

        // IO write with 3 wait states
        run_txn(3'd4, 16'h0042, 8'hFF, 3, 8'h00, 0);
        idle_cycle();
        chk("iowr_wr_low", 64'(last_low), 64'd5);
        chk("iowr_err", 64'(last_err), 64'd0);

        // memory read, READY stuck low -> timeout after WAIT_MAX TW
        run_txn(3'd1, 16'h1234, 8'h00, 1000, 8'h55, 0);
        idle_cycle();
        chk("to_rd_low", 64'(last_low), 64'(WAIT_MAX + 2));
        chk("to_err", 64'(last_err), 64'd1);
        chk("to_rdata", 64'(rdata), 64'h76);

        // back-to-back: second request raised in the done cycle
        run_txn(3'd3, 16'h00C3, 8'h00, 0, 8'h81, 0);
        run_txn(3'd2, 16'h4411, 8'h5A, 1, 8'h00, 0);

        // HOLD raised in T2 of a mem write; pending request waits behind THOLD
        run_txn(3'd2, 16'h8001, 8'hA5, 0, 8'h00, 1);
        push(idle_row()); pend_done = 1'b0; pend_err = 1'b0;
        req = 1'b1; req_type = 3'd1; req_addr = 16'h0102; ad_in = 8'h99;
        tick();
        push(hold_row()); tick();
        chk("hold_hlda", 64'({HLDA, bus_oe}), 64'b10);
        push(hold_row()); HOLD = 1'b0; tick();
        run_txn(3'd1, 16'h0102, 8'h00, 0, 8'h99, 0);
        idle_cycle();
        chk("hold_rdata", 64'(rdata), 64'h99);

        // reserved type
        run_txn(3'd6, 16'hBEEF, 8'h00, 0, 8'h00, 0);
        idle_cycle();
        chk("rsv_err", 64'(last_err), 64'd1);
        chk("rsv_no_strobe", 64'(last_low), 64'd0);

        // reset asserted during TW
        push(idle_row());
        req = 1'b1; req_type = 3'd1; req_addr = 16'h3344; ad_in = 8'hEE; READY = 1'b0;
        tick();
        req = 1'b0;
        push(t1_row(3'd1, 16'h3344)); tick();
        push(strobe_row(3'd1, 16'h3344, 8'h00)); tick();
        push(strobe_row(3'd1, 16'h3344, 8'h00)); tick();
        #1 rst = 1'b0;
        #1;
        chk("rst_tw", 64'({busy, done, ALE, ad_oe, RDn, WRn}), 64'b000011);
        @(posedge clk); #2;
        rst = 1'b1; READY = 1'b1; rd_m = 8'h00; pend_done = 1'b0; pend_err = 1'b0;
        idle_cycle();
        idle_cycle();
        chk("rst_rdata", 64'(rdata), 64'h00);
        idle_cycle();

        if (expq.size() != 0) chk("queue_drained", 64'(expq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
